// File: rtl/multiword_adder_seq_if.sv
// Handshake bundle for the multi-word add/subtract stage.
// The master side supplies operands and takes results. The slave side is the stage itself.
interface multiword_adder_seq_if #(
    parameter int WORDS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   in_a;
    logic [16*WORDS-1:0]   in_b;
    logic                  in_sub;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   out_sum;
    logic                  out_cout;
    logic                  out_ovf;
    logic                  busy;

    modport master (
        output in_valid, in_a, in_b, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );
endinterface

// File: rtl/multiword_adder_seq.sv
// Sequential multi-precision adder/subtractor.
// One 16-bit slice is added per cycle, LSB slice first, through a two-level 16-bit CLA.
module cla16_adder (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        c_i,
    output logic [15:0] sum_o,
    output logic [1:0]  carry_msb_o
);
    function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (&p[1:0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p[3:0] & ci);
        return c;
    endfunction

    logic [15:0]      g, p, c;
    logic [3:0][3:0]  grp_c;
    logic [3:0]       gg, pg, blk_c, blk_ci;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Group generate/propagate feed the second-level lookahead for block carry-ins
    for (genvar j = 0; j < 4; j++) begin : g_grp
        assign grp_c[j] = cla4(g[4*j +: 4], p[4*j +: 4], 1'b0);
        assign gg[j]    = grp_c[j][3];
        assign pg[j]    = &p[4*j +: 4];
    end

    assign blk_c  = cla4(gg, pg, c_i);
    assign blk_ci = {blk_c[2:0], c_i};

    for (genvar j = 0; j < 4; j++) begin : g_blk
        assign c[4*j +: 4] = cla4(g[4*j +: 4], p[4*j +: 4], blk_ci[j]);
    end

    assign sum_o       = p ^ {c[14:0], c_i};
    assign carry_msb_o = c[15:14];
endmodule

module multiword_adder_seq #(
    parameter int WORDS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    multiword_adder_seq_if.slave  bus
);
    localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q;
    logic [WORDS-1:0][15:0]  a_q, b_q, sum_q;
    logic [IDXW-1:0]         idx_q;
    logic                    carry_q;
    logic                    cout_q, ovf_q;
    logic                    valid_q, ready_q, busy_q;

    logic [15:0]             add_sum_d;
    logic [1:0]              add_c_d;

    cla16_adder u_cla (
        .a_i         (a_q[idx_q]),
        .b_i         (b_q[idx_q]),
        .c_i         (carry_q),
        .sum_o       (add_sum_d),
        .carry_msb_o (add_c_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtract is folded into A + ~B + 1 with the +1 as initial carry
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        carry_q <= bus.in_sub;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= add_sum_d;
                    carry_q      <= add_c_d[1];
                    if (idx_q == IDXW'(WORDS - 1)) begin
                        cout_q  <= add_c_d[1];
                        ovf_q   <= add_c_d[1] ^ add_c_d[0];
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_multiword_adder_seq.sv
// Directed-vector bench for multiword_adder_seq at WORDS=3.
// Each scenario task drives stimulus and checks inline against hand-computed values.
module tb_multiword_adder_seq;
    localparam int WORDS = 3;
    localparam int W     = 16*WORDS;

    logic clk, rst;
    int   checks = 0;
    int   errors = 0;

    multiword_adder_seq_if #(.WORDS(WORDS)) bus ();

    multiword_adder_seq #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper: accept one operation, wait for the result, then take it.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         output logic [W-1:0] sum, output logic cout, output logic ovf,
                         output int lat);
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        bus.in_a = a; bus.in_b = b; bus.in_sub = sub; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        sum = bus.out_sum; cout = bus.out_cout; ovf = bus.out_ovf;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b ready=%b busy=%b required 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        checks++;
        if (bus.out_sum !== '0 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: sum=%h cout=%b ovf=%b required 0 0 0",
                     bus.out_sum, bus.out_cout, bus.out_ovf);
        end
    endtask

    task automatic test_add_chain();
        logic [W-1:0] s; logic co, ov; int lat;
        do_op(48'h0000_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, s, co, ov, lat);
        checks++;
        if (s !== 48'h0001_0000_0000 || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL add_chain: sum=%h cout=%b ovf=%b required 000100000000 0 0", s, co, ov);
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL add_latency: got %0d required 3", lat);
        end
    endtask

    task automatic test_sub();
        logic [W-1:0] s; logic co, ov; int lat;
        do_op(48'h5, 48'h7, 1'b1, s, co, ov, lat);
        checks++;
        if (s !== 48'hFFFF_FFFF_FFFE || co !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow: sum=%h cout=%b ovf=%b required fffffffffffe 0 0", s, co, ov);
        end
        do_op(48'h7, 48'h5, 1'b1, s, co, ov, lat);
        checks++;
        if (s !== 48'h2 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL sub_noborrow: sum=%h cout=%b ovf=%b required 000000000002 1 0", s, co, ov);
        end
    endtask

    task automatic test_ovf_wrap();
        logic [W-1:0] s; logic co, ov; int lat;
        do_op(48'h7FFF_FFFF_FFFF, 48'h1, 1'b0, s, co, ov, lat);
        checks++;
        if (s !== 48'h8000_0000_0000 || co !== 1'b0 || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: sum=%h cout=%b ovf=%b required 800000000000 0 1", s, co, ov);
        end
        do_op(48'hFFFF_FFFF_FFFF, 48'h1, 1'b0, s, co, ov, lat);
        checks++;
        if (s !== 48'h0 || co !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL wrap: sum=%h cout=%b ovf=%b required 000000000000 1 0", s, co, ov);
        end
        do_op(48'h8000_0000_0000, 48'h1, 1'b1, s, co, ov, lat);
        checks++;
        if (s !== 48'h7FFF_FFFF_FFFF || co !== 1'b1 || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg: sum=%h cout=%b ovf=%b required 7fffffffffff 1 1", s, co, ov);
        end
    endtask

    task automatic test_backpressure();
        int n;
        bus.in_a = 48'h0001_0000_1234; bus.in_b = 48'h0002_0000_1111;
        bus.in_sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a = 48'h1111_1111_1111 * (i + 1);
            bus.in_b = 48'h0F0F_0F0F_0F0F ^ 48'(i);
            bus.in_sub = i[0];
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_sum !== 48'h0003_0000_2345 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b ready=%b sum=%h cout=%b ovf=%b required 1 0 000300002345 0 0",
                         i, bus.out_valid, bus.in_ready, bus.out_sum, bus.out_cout, bus.out_ovf);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 ||
            bus.out_sum !== 48'h0003_0000_2345) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b busy=%b sum=%h required 0 1 0 000300002345",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_sum);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s; logic co, ov; int lat;
        bus.in_a = 48'h1234; bus.in_b = 48'h1; bus.in_sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_sum !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b ready=%b busy=%b sum=%h required 0 1 0 0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_sum);
        end
        do_op(48'h1, 48'h1, 1'b0, s, co, ov, lat);
        checks++;
        if (s !== 48'h2 || co !== 1'b0 || ov !== 1'b0 || lat !== 3) begin
            errors++;
            $display("FAIL after_reset: sum=%h cout=%b ovf=%b lat=%0d required 000000000002 0 0 3",
                     s, co, ov, lat);
        end
    endtask

    task automatic test_back_to_back();
        int n, nacc, nres;
        int acc [2];
        logic [W-1:0] res [2];
        n = 0; nacc = 0; nres = 0;
        acc[0] = 0; acc[1] = 0; res[0] = '0; res[1] = '0;
        bus.in_a = 48'h1; bus.in_b = 48'h2; bus.in_sub = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        while (nres < 2 && n < 40) begin
            if (bus.out_valid) begin
                res[nres] = bus.out_sum;
                nres++;
            end
            if (bus.in_ready && bus.in_valid && nacc < 2) begin
                acc[nacc] = n + 1;
                nacc++;
            end
            @(posedge clk); #1; n++;
            if (nacc == 1) begin
                bus.in_a = 48'h10; bus.in_b = 48'h20;
            end
            if (nacc == 2) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        checks++;
        if (nres !== 2 || res[0] !== 48'h3 || res[1] !== 48'h30) begin
            errors++;
            $display("FAIL b2b_results: count=%0d r0=%h r1=%h required 2 000000000003 000000000030",
                     nres, res[0], res[1]);
        end
        checks++;
        if (nacc !== 2 || (acc[1] - acc[0]) !== WORDS + 2) begin
            errors++;
            $display("FAIL b2b_spacing: accepts=%0d gap=%0d required 2 %0d",
                     nacc, acc[1] - acc[0], WORDS + 2);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_sub = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_add_chain();
        test_sub();
        test_ovf_wrap();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiword_adder_seq.md
Name: multiword_adder_seq

Overview:
Sequential multi-precision add/subtract stage built around the existing 16-bit carry-lookahead adder. It accepts two (16*WORDS)-bit operands over a valid/ready handshake. It then feeds one 16-bit slice per cycle to the adder, least-significant slice first, chaining carry-out to carry-in. It returns the assembled sum with carry and signed-overflow flags over a second valid/ready handshake.

Parameters:
WORDS, 3, number of 16-bit slices; operand and result width is 16*WORDS; legal range 1..8.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair presented
in_ready  output  1  stage can accept operands
in_a  input  16*WORDS  operand A
in_b  input  16*WORDS  operand B
in_sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_sum  output  16*WORDS  result
out_cout  output  1  carry out of MSB; for subtract, 1 = no borrow
out_ovf  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- One clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Reset values: out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0, in_ready=1, slice index=0, carry register=0.
- IDLE:
  - in_ready=1.
  - On a clock edge with in_valid=1, latch in_a into A_reg. Latch (in_sub ? ~in_b : in_b) into B_reg. Set carry register = in_sub, index = 0. Go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0.
  - Each cycle, add slice[index] of A_reg and B_reg plus the carry register using the 16-bit CLA adder.
  - Write the 16-bit sum into out_sum[16*index +: 16]. Update carry register = adder carry[15].
  - When index==WORDS-1:
    - out_cout = adder carry[15].
    - out_ovf = carry[15] XOR carry[14], i.e. carry into the MSB XOR carry out of the MSB.
    - Go to DONE.
  - Otherwise index increments.
- DONE:
  - out_valid=1.
  - out_sum, out_cout and out_ovf are held stable while out_ready=0.
  - On an edge with out_ready=1: go to IDLE, out_valid=0. out_sum and flags keep their values until overwritten.
  - No new accept occurs in DONE; in_ready returns to 1 the cycle after the result is taken.
- Latency and throughput:
  - out_valid rises WORDS edges after the accept edge; 3 cycles for the default.
  - Minimum spacing between accepts is WORDS+2 cycles.
- Input handling:
  - in_a, in_b and in_sub are sampled only on the accept edge; later changes are ignored.
  - in_valid is ignored outside IDLE and is not queued.
- Arithmetic:
  - Result is modulo 2^(16*WORDS).
  - Subtract is A + ~B + 1; the borrow is the inverse of out_cout.
- Reset asserted in any state aborts the operation on that edge. The partial sum is discarded and all reset values apply on the next cycle.
- Simultaneous rst and in_valid: reset wins; nothing is accepted.
- WORDS=1: RUN lasts exactly one cycle.

Test Plan:
1. Add with carry chaining, WORDS=3: A=0x0000_FFFF_FFFF, B=0x0000_0000_0001, sub=0 -> out_sum=0x0001_0000_0000, cout=0, ovf=0. out_valid is high exactly 3 cycles after the accept edge.
2. Subtract with borrow: A=0x0000_0000_0005, B=0x0000_0000_0007, sub=1 -> out_sum=0xFFFF_FFFF_FFFE, cout=0, ovf=0. Then A=7, B=5 -> out_sum=2, cout=1, ovf=0.
3. Overflow and wrap:
   - 0x7FFF_FFFF_FFFF + 1 -> out_sum=0x8000_0000_0000, ovf=1, cout=0.
   - 0xFFFF_FFFF_FFFF + 1 -> out_sum=0, cout=1, ovf=0.
   - 0x8000_0000_0000 - 1 -> out_sum=0x7FFF_FFFF_FFFF, ovf=1, cout=1.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_sum, flags and out_valid stay constant, and in_ready=0. Toggle in_a/in_b and hold in_valid=1 during this time -> no effect. Then out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next cycle.
5. Reset mid-operation: assert rst for one cycle during the 2nd RUN cycle -> next cycle has out_valid=0, in_ready=1, busy=0, out_sum=0. A following operation 1+1 returns 2 with normal latency.
6. Back-to-back operations: keep in_valid=1 with out_ready=1 tied high, feeding 0x1+0x2 then 0x10+0x20 -> results 0x3 then 0x30 in order. Accept edges are WORDS+2=5 cycles apart.
